// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per op,
// byte-lane steering, misalignment rejection and ack-timeout abort.
module load_store_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        ex_ready,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        misaligned,
  output logic        timeout_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   wb_data_q;
  logic [3:0]    wstrb_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          mis_q;
  logic          tmo_q;

  logic          legal;
  logic          sz_b, sz_h, sz_w;
  logic          mis_a;
  logic          accept;
  logic          reject;
  logic          expire;
  logic [31:0]   lane_data;
  logic [3:0]    lane_strb;
  logic [7:0]    rd_b;
  logic [15:0]   rd_h;
  logic [31:0]   ext;

  assign sz_b = (ex_funct3[1:0] == 2'b00);
  assign sz_h = (ex_funct3[1:0] == 2'b01);
  assign sz_w = (ex_funct3[1:0] == 2'b10);

  // BU/HU exist only for loads; both or neither op bit is not an op
  always_comb begin
    legal = 1'b0;
    if (ex_valid && (ex_load ^ ex_store)) begin
      unique case (ex_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b100, 3'b101:         legal = ex_load;
        default:                legal = 1'b0;
      endcase
    end
  end

  assign mis_a  = (sz_h & ex_addr[0]) | (sz_w & |ex_addr[1:0]);
  assign accept = (state_q == IDLE) & legal & ~mis_a;
  assign reject = (state_q == IDLE) & legal & mis_a;
  assign expire = (state_q == REQ) & ~mem_ack & (cnt_q == LAST);

  always_comb begin
    lane_data = ex_wdata;
    lane_strb = 4'b1111;
    unique case (1'b1)
      sz_b: begin
        lane_data = {4{ex_wdata[7:0]}};
        lane_strb = 4'b0001 << ex_addr[1:0];
      end
      sz_h: begin
        lane_data = {2{ex_wdata[15:0]}};
        lane_strb = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_data = ex_wdata;
        lane_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rd_b = mem_rdata[7:0];
    unique case (off_q)
      2'd0: rd_b = mem_rdata[7:0];
      2'd1: rd_b = mem_rdata[15:8];
      2'd2: rd_b = mem_rdata[23:16];
      2'd3: rd_b = mem_rdata[31:24];
      default: rd_b = mem_rdata[7:0];
    endcase
    rd_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  always_comb begin
    ext = mem_rdata;
    unique case (f3_q)
      3'b000: ext = {{24{rd_b[7]}}, rd_b};
      3'b001: ext = {{16{rd_h[15]}}, rd_h};
      3'b100: ext = {24'h0, rd_b};
      3'b101: ext = {16'h0, rd_h};
      default: ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (mem_ack) state_d = we_q ? IDLE : DONE;
        else if (cnt_q == LAST) state_d = IDLE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      wb_data_q <= '0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= reject;
      tmo_q   <= expire;
      if (accept) begin
        addr_q  <= {ex_addr[31:2], 2'b00};
        we_q    <= ex_store;
        wdata_q <= lane_data;
        wstrb_q <= ex_store ? lane_strb : 4'b0000;
        f3_q    <= ex_funct3;
        off_q   <= ex_addr[1:0];
        cnt_q   <= '0;
      end else if (state_q == REQ && !mem_ack) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == REQ && mem_ack && !we_q) begin
        wb_data_q <= ext;
      end
    end
  end

  assign ex_ready    = (state_q == IDLE);
  assign stall       = ~ex_ready;
  assign mem_req     = (state_q == REQ);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign wb_valid    = (state_q == DONE);
  assign wb_data     = wb_data_q;
  assign misaligned  = mis_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-cycle expectation schedule built from
// op-level rules, checked every cycle, plus hand-computed literals.
module tb_load_store_unit;

  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        ex_ready;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        timeout_err;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_ready(ex_ready), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .misaligned(misaligned), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        req;
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  wstrb;
    bit        wb;
    bit [31:0] wbd;
    bit        mis;
    bit        tmo;
  } exp_t;

  exp_t sched [0:2047];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int n_req = 0, n_mis = 0, n_tmo = 0, n_wb = 0;
  int d_req, d_mis, d_tmo, d_wb;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_wstrb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit m_legal(bit ld, bit st, bit [2:0] f3);
    if (!(ld ^ st)) return 1'b0;
    if (f3 inside {3'd0, 3'd1, 3'd2}) return 1'b1;
    return ld && (f3 inside {3'd4, 3'd5});
  endfunction

  function automatic bit m_mis(bit [2:0] f3, bit [31:0] ad);
    int sz;
    sz = 1 << f3[1:0];
    return (ad % 32'(sz)) != 0;
  endfunction

  function automatic bit [35:0] m_lanes(bit [2:0] f3, bit [31:0] ad,
                                        bit [31:0] d);
    int sz;
    bit [3:0] sb;
    bit [31:0] wd;
    sz = 1 << f3[1:0];
    sb = 4'(((1 << sz) - 1) << ad[1:0]);
    case (sz)
      1: wd = {24'h0, d[7:0]} * 32'h01010101;
      2: wd = {16'h0, d[15:0]} * 32'h00010001;
      default: wd = d;
    endcase
    return {wd, sb};
  endfunction

  function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] ad,
                                       bit [31:0] rd);
    bit [31:0] sh;
    sh = rd >> (8 * ad[1:0]);
    case (f3)
      3'd0: return {{24{sh[7]}}, sh[7:0]};
      3'd1: return {{16{sh[15]}}, sh[15:0]};
      3'd4: return {24'h0, sh[7:0]};
      3'd5: return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (mem_req) begin
      n_req++;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
      last_wstrb = mem_wstrb;
    end
    if (misaligned) n_mis++;
    if (timeout_err) n_tmo++;
    if (wb_valid) n_wb++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en && cyc < 2048) begin
      e = sched[cyc];
      chk("ex_ready", {31'h0, ex_ready}, {31'h0, !(e.req || e.wb)});
      chk("stall", {31'h0, stall}, {31'h0, e.req || e.wb});
      chk("mem_req", {31'h0, mem_req}, {31'h0, e.req});
      chk("wb_valid", {31'h0, wb_valid}, {31'h0, e.wb});
      chk("misaligned", {31'h0, misaligned}, {31'h0, e.mis});
      chk("timeout_err", {31'h0, timeout_err}, {31'h0, e.tmo});
      if (e.req) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {31'h0, mem_we}, {31'h0, e.we});
        chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
      end
      if (e.wb) chk("wb_data", wb_data, e.wbd);
    end
  end

  // k: ack on the k-th request cycle; 0 means never ack
  task automatic op(input bit ld, input bit st, input bit [2:0] f3,
                    input bit [31:0] ad, input bit [31:0] wd,
                    input bit [31:0] rd, input int k);
    int a, n, s_req, s_mis, s_tmo, s_wb;
    exp_t e;
    s_req = n_req; s_mis = n_mis; s_tmo = n_tmo; s_wb = n_wb;
    @(negedge clk);
    a = cyc;
    ex_valid = 1'b1; ex_load = ld; ex_store = st;
    ex_funct3 = f3; ex_addr = ad; ex_wdata = wd;
    n = 0;
    if (m_legal(ld, st, f3) && m_mis(f3, ad)) begin
      sched[a+1].mis = 1'b1;
    end else if (m_legal(ld, st, f3)) begin
      n = (k < 1 || k > MW) ? MW : k;
      e = '{default: 0};
      e.req = 1'b1;
      e.we = st;
      e.addr = ad & ~32'h3;
      if (st) {e.wdata, e.wstrb} = m_lanes(f3, ad, wd);
      for (int j = 1; j <= n; j++) sched[a+j] = e;
      if (k >= 1 && k <= MW) begin
        if (ld) begin
          sched[a+n+1].wb = 1'b1;
          sched[a+n+1].wbd = m_load(f3, ad, rd);
        end
      end else begin
        sched[a+n+1].tmo = 1'b1;
      end
    end
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    for (int j = 1; j <= n; j++) begin
      if (j == k) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    @(negedge clk);
    #1;
    d_req = n_req - s_req; d_mis = n_mis - s_mis;
    d_tmo = n_tmo - s_tmo; d_wb = n_wb - s_wb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s_req, s_wb;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ex_ready}, 32'h1);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_wb", {31'h0, wb_valid}, 32'h0);
    chk("rst_wbdata", wb_data, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 3);
    chk("sw_req_cycles", d_req, 3);
    chk("sw_wstrb", {28'h0, last_wstrb}, 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);
    chk("sw_no_wb", d_wb, 0);

    op(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 1);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wb", d_wb, 1);
    op(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 1);
    chk("lbu_data", wb_data, 32'h00000080);

    op(0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 2);
    chk("sh_addr", last_addr, 32'h200);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_wstrb", {28'h0, last_wstrb}, 32'hC);

    op(1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 1);
    chk("lw_mis_pulse", d_mis, 1);
    chk("lw_mis_noreq", d_req, 0);

    op(1, 0, 3'd1, 32'h106, 32'h0, 32'h80017FFF, 1);
    chk("lh_data", wb_data, 32'hFFFF8001);
    op(1, 0, 3'd5, 32'h104, 32'h0, 32'h80017FFF, 2);
    chk("lhu_data", wb_data, 32'h00007FFF);

    op(0, 1, 3'd0, 32'h102, 32'h1234565A, 32'h0, 1);
    chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
    chk("sb_wstrb", {28'h0, last_wstrb}, 32'h4);

    op(0, 1, 3'd1, 32'h201, 32'h1, 32'h0, 1);
    chk("sh_mis", d_mis, 1);

    op(1, 1, 3'd2, 32'h101, 32'h0, 32'h0, 1);
    chk("both_ign", d_req + d_mis, 0);
    op(0, 0, 3'd2, 32'h100, 32'h0, 32'h0, 1);
    chk("none_ign", d_req + d_mis, 0);
    op(0, 1, 3'd4, 32'h100, 32'hFF, 32'h0, 1);
    chk("sbu_ign", d_req + d_mis, 0);

    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);

    op(1, 0, 3'd2, 32'h10, 32'h0, 32'h0, 0);
    chk("to_req_cycles", d_req, MW);
    chk("to_pulse", d_tmo, 1);
    chk("to_no_wb", d_wb, 0);

    op(1, 0, 3'd2, 32'h20, 32'h0, 32'h12345678, MW);
    chk("last_ack_data", wb_data, 32'h12345678);
    chk("last_ack_no_to", d_tmo, 0);

    op(1, 0, 3'd2, 32'h300, 32'h0, 32'hCAFEF00D, 2);
    chk("lw_data", wb_data, 32'hCAFEF00D);

    chk_en = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'd2; ex_addr = 32'h10;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0;
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", {31'h0, mem_req}, 32'h0);
    chk("rst_async_ready", {31'h0, ex_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    s_req = n_req; s_wb = n_wb;
    mem_ack = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_req", n_req - s_req, 0);
    chk("post_rst_wb", n_wb - s_wb, 0);
    chk_en = 1'b1;

    op(1, 0, 3'd4, 32'h101, 32'h0, 32'h0000C300, 1);
    chk("recover_lbu", wb_data, 32'h000000C3);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
